// File: rtl/win3x3_linebuf.sv
// 3x3 sliding-window generator for a 3-channel (RGB) raster stream, two-line buffered.
// Optional macro WINBUF_SOF_SYNC_EN adds i_sof, which forces the accepted pixel to (0,0).
module win3x3_linebuf #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int CW    = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [23:0] i_pixel_data,
  input  logic        i_pixel_data_valid,
`ifdef WINBUF_SOF_SYNC_EN
  input  logic        i_sof,
`endif
  output logic [71:0] o_pixel_data1,
  output logic [71:0] o_pixel_data2,
  output logic [71:0] o_pixel_data3,
  output logic        o_pixel_data_valid,
  output logic        o_frame_done
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] TWO      = CW'(2);

  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [CW-1:0] col_eff, row_eff;
  logic          accept, last_col, last_row;
  logic          valid_q, valid_d, done_q, done_d;
  logic [AW-1:0] lb_addr;
  logic [23:0]   lb1_rd, lb2_rd;
  logic [23:0]   lb1_mem [IMG_W];
  logic [23:0]   lb2_mem [IMG_W];
  logic [2:0][23:0] col_pix;
  logic [2:0][71:0] win_q, win_d;

  assign accept = i_pixel_data_valid;

  // Position of the pixel being presented; i_sof overrides the counters when enabled.
  always_comb begin
    col_eff = col_q;
    row_eff = row_q;
`ifdef WINBUF_SOF_SYNC_EN
    if (i_sof) begin
      col_eff = '0;
      row_eff = '0;
    end
`endif
  end

  assign last_col = (col_eff == COL_LAST);
  assign last_row = (row_eff == ROW_LAST);
  assign lb_addr  = col_eff[AW-1:0];

  // Asynchronous reads give the old contents before this edge's write lands.
  assign lb1_rd = lb1_mem[lb_addr];
  assign lb2_rd = lb2_mem[lb_addr];

  assign col_pix[0] = lb2_rd;
  assign col_pix[1] = lb1_rd;
  assign col_pix[2] = i_pixel_data;

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_eff + 1'b1;
      end else begin
        col_d = col_eff + 1'b1;
        row_d = row_eff;
      end
      valid_d = (row_eff >= TWO) && (col_eff >= TWO);
      done_d  = last_col && last_row;
    end
  end

  // Each row of the window shifts left by one byte; the new column enters at col_idx 2.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int ch = 0; ch < 3; ch++) begin
        for (int r = 0; r < 3; r++) begin
          win_d[ch][(r*3+0)*8 +: 8] = win_q[ch][(r*3+1)*8 +: 8];
          win_d[ch][(r*3+1)*8 +: 8] = win_q[ch][(r*3+2)*8 +: 8];
          win_d[ch][(r*3+2)*8 +: 8] = col_pix[r][ch*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      win_q   <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  // Line buffers carry no reset; rows 0/1 of every frame are gated, so stale data never shows.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb2_mem[lb_addr] <= lb1_rd;
      lb1_mem[lb_addr] <= i_pixel_data;
    end
  end

  assign o_pixel_data1      = win_q[0];
  assign o_pixel_data2      = win_q[1];
  assign o_pixel_data3      = win_q[2];
  assign o_pixel_data_valid = valid_q;
  assign o_frame_done       = done_q;

endmodule

// File: tb/tb_win3x3_linebuf.sv
// Directed bench for win3x3_linebuf: a 4x4 instance for hand-checked windows and a 64x64
// instance compared against a window model built from the stored frame.
module tb_win3x3_linebuf;

  logic        clk;
  logic        rst_n;
  logic [23:0] pix, bpix;
  logic        vin, bvin;
  logic        sof;
  logic [71:0] s_d1, s_d2, s_d3, b_d1, b_d2, b_d3;
  logic        s_v, s_fd, b_v, b_fd;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  logic [215:0] cap_q[$];
  int           cap_idx[$];
  bit           cap_lat[$];
  bit           cap_fd[$];
  logic [23:0]  img [4096];

  win3x3_linebuf #(.IMG_W(4), .IMG_H(4), .CW(10)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_pixel_data(pix), .i_pixel_data_valid(vin),
`ifdef WINBUF_SOF_SYNC_EN
    .i_sof(sof),
`endif
    .o_pixel_data1(s_d1), .o_pixel_data2(s_d2), .o_pixel_data3(s_d3),
    .o_pixel_data_valid(s_v), .o_frame_done(s_fd)
  );

  win3x3_linebuf #(.IMG_W(64), .IMG_H(64), .CW(10)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_pixel_data(bpix), .i_pixel_data_valid(bvin),
`ifdef WINBUF_SOF_SYNC_EN
    .i_sof(1'b0),
`endif
    .o_pixel_data1(b_d1), .o_pixel_data2(b_d2), .o_pixel_data3(b_d3),
    .o_pixel_data_valid(b_v), .o_frame_done(b_fd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected window n (raster order) of a 4x4 frame whose ch1 value is index+off.
  function automatic logic [215:0] exp_win(input int off, input int n);
    int r, c, p;
    logic [215:0] w;
    r = 2 + n / 2;
    c = 2 + n % 2;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      p = (r - 2 + k / 3) * 4 + (c - 2 + k % 3);
      w[k*8 +: 8]       = 8'(p + off);
      w[72 + k*8 +: 8]  = 8'(p + off + 32);
      w[144 + k*8 +: 8] = 8'(p + off + 64);
    end
    return w;
  endfunction

  task automatic clear_caps();
    cap_q.delete();
    cap_idx.delete();
    cap_lat.delete();
    cap_fd.delete();
    fd_cnt = 0;
  endtask

  // Drives npix pixels of a 4x4 frame into the small DUT, capturing every window strobe.
  task automatic drive_frame(input int off, input bit toggle, input int npix, input bit sof_first);
    int sent;
    bit last_acc;
    sent = 0;
    last_acc = 1'b0;
    do begin
      @(negedge clk);
      if (s_v) begin
        cap_q.push_back({s_d3, s_d2, s_d1});
        cap_idx.push_back(sent - 1);
        cap_lat.push_back(last_acc);
        cap_fd.push_back(s_fd);
      end
      if (s_fd) fd_cnt++;
      if (sent < npix && !(toggle && last_acc)) begin
        vin = 1'b1;
        pix = {8'(sent + off + 64), 8'(sent + off + 32), 8'(sent + off)};
        sof = sof_first && (sent == 0);
        sent++;
        last_acc = 1'b1;
      end else begin
        vin = 1'b0;
        sof = 1'b0;
        last_acc = 1'b0;
      end
    end while (sent < npix || last_acc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vin = 1'b0; bvin = 1'b0; sof = 1'b0; pix = '0; bpix = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_d1, s_d2, s_d3, s_v, s_fd} !== '0) begin
      errors++; $display("FAIL reset_small got %h %h %h v=%b fd=%b exp 0", s_d1, s_d2, s_d3, s_v, s_fd);
    end
    checks++;
    if ({b_d1, b_d2, b_d3, b_v, b_fd} !== '0) begin
      errors++; $display("FAIL reset_big got %h v=%b fd=%b exp 0", b_d1, b_v, b_fd);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    clear_caps();
    drive_frame(0, 1'b0, 16, 1'b0);
    checks++;
    if (cap_q.size() != 4) begin errors++; $display("FAIL single_count got %0d exp 4", cap_q.size()); end
    for (int n = 0; n < 4 && n < cap_q.size(); n++) begin
      checks++;
      if (cap_q[n] !== exp_win(0, n)) begin
        errors++; $display("FAIL single_win%0d got %h exp %h", n, cap_q[n], exp_win(0, n));
      end
      checks++;
      if (cap_idx[n] != (2 + n / 2) * 4 + 2 + n % 2 || !cap_lat[n]) begin
        errors++; $display("FAIL single_lat%0d got idx %0d lat %0b exp idx %0d lat 1", n, cap_idx[n], cap_lat[n], (2 + n / 2) * 4 + 2 + n % 2);
      end
      checks++;
      if (cap_fd[n] != (n == 3)) begin
        errors++; $display("FAIL single_fd%0d got %0b exp %0b", n, cap_fd[n], n == 3);
      end
    end
    if (cap_q.size() == 4) begin
      checks++;
      if (cap_q[0][71:0] !== 72'h0a0908060504020100) begin
        errors++; $display("FAIL single_first got %h exp 0a0908060504020100", cap_q[0][71:0]);
      end
      checks++;
      if (cap_q[3][71:0] !== 72'h0f0e0d0b0a09070605) begin
        errors++; $display("FAIL single_last got %h exp 0f0e0d0b0a09070605", cap_q[3][71:0]);
      end
    end
    checks++;
    if (fd_cnt != 1) begin errors++; $display("FAIL single_fdcnt got %0d exp 1", fd_cnt); end
  endtask

  task automatic test_toggle();
    clear_caps();
    drive_frame(0, 1'b1, 16, 1'b0);
    checks++;
    if (cap_q.size() != 4) begin errors++; $display("FAIL toggle_count got %0d exp 4", cap_q.size()); end
    for (int n = 0; n < 4 && n < cap_q.size(); n++) begin
      checks++;
      if (cap_q[n] !== exp_win(0, n)) begin
        errors++; $display("FAIL toggle_win%0d got %h exp %h", n, cap_q[n], exp_win(0, n));
      end
      checks++;
      if (cap_idx[n] != (2 + n / 2) * 4 + 2 + n % 2 || !cap_lat[n] || cap_fd[n] != (n == 3)) begin
        errors++; $display("FAIL toggle_tim%0d got idx %0d lat %0b fd %0b", n, cap_idx[n], cap_lat[n], cap_fd[n]);
      end
    end
    @(negedge clk);
    checks++;
    if (s_d1 !== 72'h0f0e0d0b0a09070605 || s_v !== 1'b0) begin
      errors++; $display("FAIL toggle_hold got %h v=%b exp 0f0e0d0b0a09070605 v=0", s_d1, s_v);
    end
  endtask

  task automatic test_back_to_back();
    clear_caps();
    drive_frame(0, 1'b0, 16, 1'b0);
    checks++;
    if (cap_q.size() != 4 || fd_cnt != 1) begin
      errors++; $display("FAIL b2b_f1 got %0d windows %0d done exp 4 1", cap_q.size(), fd_cnt);
    end
    clear_caps();
    drive_frame(100, 1'b0, 16, 1'b0);
    checks++;
    if (cap_q.size() != 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", cap_q.size()); end
    for (int n = 0; n < 4 && n < cap_q.size(); n++) begin
      checks++;
      if (cap_q[n] !== exp_win(100, n)) begin
        errors++; $display("FAIL b2b_win%0d got %h exp %h", n, cap_q[n], exp_win(100, n));
      end
      checks++;
      if (cap_idx[n] != (2 + n / 2) * 4 + 2 + n % 2 || cap_fd[n] != (n == 3)) begin
        errors++; $display("FAIL b2b_tim%0d got idx %0d fd %0b", n, cap_idx[n], cap_fd[n]);
      end
    end
    if (cap_q.size() > 0) begin
      checks++;
      if (cap_q[0][71:0] !== 72'h6e6d6c6a6968666564) begin
        errors++; $display("FAIL b2b_first got %h exp 6e6d6c6a6968666564", cap_q[0][71:0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_caps();
    drive_frame(0, 1'b0, 6, 1'b0);
    checks++;
    if (cap_q.size() != 0) begin errors++; $display("FAIL midrst_partial got %0d windows exp 0", cap_q.size()); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (s_d1 !== '0 || s_d3 !== '0 || s_v !== 1'b0) begin
      errors++; $display("FAIL midrst_clear got %h %h v=%b exp 0", s_d1, s_d3, s_v);
    end
    rst_n = 1'b1;
    clear_caps();
    drive_frame(0, 1'b0, 16, 1'b0);
    checks++;
    if (cap_q.size() != 4 || fd_cnt != 1) begin
      errors++; $display("FAIL midrst_count got %0d windows %0d done exp 4 1", cap_q.size(), fd_cnt);
    end
    for (int n = 0; n < 4 && n < cap_q.size(); n++) begin
      checks++;
      if (cap_q[n] !== exp_win(0, n) || cap_idx[n] != (2 + n / 2) * 4 + 2 + n % 2) begin
        errors++; $display("FAIL midrst_win%0d got %h idx %0d exp %h", n, cap_q[n], cap_idx[n], exp_win(0, n));
      end
    end
  endtask

`ifdef WINBUF_SOF_SYNC_EN
  task automatic test_sof();
    clear_caps();
    drive_frame(0, 1'b0, 7, 1'b0);
    clear_caps();
    drive_frame(0, 1'b0, 16, 1'b1);
    checks++;
    if (cap_q.size() != 4 || fd_cnt != 1) begin
      errors++; $display("FAIL sof_count got %0d windows %0d done exp 4 1", cap_q.size(), fd_cnt);
    end
    for (int n = 0; n < 4 && n < cap_q.size(); n++) begin
      checks++;
      if (cap_q[n] !== exp_win(0, n) || cap_fd[n] != (n == 3)) begin
        errors++; $display("FAIL sof_win%0d got %h fd %0b exp %h", n, cap_q[n], cap_fd[n], exp_win(0, n));
      end
    end
  endtask
`endif

  task automatic test_random_frame();
    int prev, r, c, nwin;
    bit ev, efd;
    logic [215:0] ew;
    for (int i = 0; i < 4096; i++) img[i] = 24'($urandom);
    prev = -1;
    nwin = 0;
    for (int i = 0; i <= 4096; i++) begin
      @(negedge clk);
      r = (prev >= 0) ? prev / 64 : 0;
      c = (prev >= 0) ? prev % 64 : 0;
      ev = (prev >= 0) && r >= 2 && c >= 2;
      efd = (prev == 4095);
      checks++;
      if (b_v !== ev || b_fd !== efd) begin
        errors++; $display("FAIL rand_strobe pix %0d got v=%b fd=%b exp v=%b fd=%b", prev, b_v, b_fd, ev, efd);
      end
      if (ev && b_v) begin
        for (int k = 0; k < 9; k++)
          for (int ch = 0; ch < 3; ch++)
            ew[ch*72 + k*8 +: 8] = img[(r - 2 + k / 3) * 64 + (c - 2 + k % 3)][ch*8 +: 8];
        checks++;
        if ({b_d3, b_d2, b_d1} !== ew) begin
          errors++; $display("FAIL rand_win pix %0d got %h exp %h", prev, {b_d3, b_d2, b_d1}, ew);
        end
        nwin++;
      end
      if (i < 4096) begin
        bvin = 1'b1; bpix = img[i]; prev = i;
      end else begin
        bvin = 1'b0; prev = -1;
      end
    end
    checks++;
    if (nwin != 3844) begin errors++; $display("FAIL rand_count got %0d exp 3844", nwin); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_toggle();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef WINBUF_SOF_SYNC_EN
    test_sof();
`endif
    test_random_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
